// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with forwarding, operand select, load-use detect; `ID_EX_PERF_COUNT_EN adds BUBBLE_COUNT/STALL_COUNT
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5,
    parameter int OP_W = 5
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            STALL,
    input  logic            FLUSH,
    input  logic            IN_VALID,
    input  logic [XLEN-1:0] IN_PC,
    input  logic [XLEN-1:0] IN_RDATA1,
    input  logic [XLEN-1:0] IN_RDATA2,
    input  logic [XLEN-1:0] IN_IMM,
    input  logic [OP_W-1:0] IN_ALUOP,
    input  logic [RA_W-1:0] IN_RS1,
    input  logic [RA_W-1:0] IN_RS2,
    input  logic [RA_W-1:0] IN_RD,
    input  logic            IN_SRC1_PC,
    input  logic            IN_SRC2_IMM,
    input  logic            IN_REG_WRITE,
    input  logic            IN_MEM_READ,
    input  logic            IN_MEM_WRITE,
    input  logic [RA_W-1:0] MEM_RD,
    input  logic            MEM_REG_WRITE,
    input  logic [XLEN-1:0] MEM_RESULT,
    input  logic [RA_W-1:0] WB_RD,
    input  logic            WB_REG_WRITE,
    input  logic [XLEN-1:0] WB_RESULT,
    output logic [XLEN-1:0] DATA1,
    output logic [XLEN-1:0] DATA2,
    output logic [OP_W-1:0] SELECT,
    output logic [XLEN-1:0] STORE_DATA,
    output logic [RA_W-1:0] RD,
    output logic            REG_WRITE,
    output logic            MEM_READ,
    output logic            MEM_WRITE,
    output logic            VALID,
    output logic            HAZARD_STALL
`ifdef ID_EX_PERF_COUNT_EN
    ,
    output logic [31:0]     BUBBLE_COUNT,
    output logic [31:0]     STALL_COUNT
`endif
);
    logic [XLEN-1:0] pc_q, rs1v_q, rs2v_q, imm_q, fwd1, fwd2;
    logic [OP_W-1:0] op_q;
    logic [RA_W-1:0] rs1_q, rs2_q, rd_q;
    logic            valid_q, rw_q, mr_q, mw_q;

    // MEM is the younger producer, so it wins over WB; x0 is never forwarded
    assign fwd1 = (MEM_REG_WRITE && MEM_RD != '0 && MEM_RD == rs1_q) ? MEM_RESULT :
                  (WB_REG_WRITE && WB_RD != '0 && WB_RD == rs1_q) ? WB_RESULT : rs1v_q;
    assign fwd2 = (MEM_REG_WRITE && MEM_RD != '0 && MEM_RD == rs2_q) ? MEM_RESULT :
                  (WB_REG_WRITE && WB_RD != '0 && WB_RD == rs2_q) ? WB_RESULT : rs2v_q;

    assign DATA1        = IN_SRC1_PC ? pc_q : fwd1;
    assign DATA2        = IN_SRC2_IMM ? imm_q : fwd2;
    assign STORE_DATA   = fwd2;
    assign SELECT       = op_q;
    assign RD           = rd_q;
    assign VALID        = valid_q;
    assign REG_WRITE    = valid_q & rw_q;
    assign MEM_READ     = valid_q & mr_q;
    assign MEM_WRITE    = valid_q & mw_q;
    assign HAZARD_STALL = valid_q && mr_q && rd_q != '0 && IN_VALID &&
                          (IN_RS1 == rd_q || IN_RS2 == rd_q) && !STALL && !FLUSH;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            pc_q    <= '0;
            rs1v_q  <= '0;
            rs2v_q  <= '0;
            imm_q   <= '0;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else if (FLUSH || (!STALL && HAZARD_STALL)) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
        end else if (STALL) begin
            // capture producers that retire while the stage is held
            rs1v_q <= fwd1;
            rs2v_q <= fwd2;
        end else begin
            valid_q <= IN_VALID;
            rw_q    <= IN_REG_WRITE;
            mr_q    <= IN_MEM_READ;
            mw_q    <= IN_MEM_WRITE;
            pc_q    <= IN_PC;
            rs1v_q  <= IN_RDATA1;
            rs2v_q  <= IN_RDATA2;
            imm_q   <= IN_IMM;
            op_q    <= IN_ALUOP;
            rs1_q   <= IN_RS1;
            rs2_q   <= IN_RS2;
            rd_q    <= IN_RD;
        end
    end

`ifdef ID_EX_PERF_COUNT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            BUBBLE_COUNT <= '0;
            STALL_COUNT  <= '0;
        end else begin
            if (HAZARD_STALL) BUBBLE_COUNT <= BUBBLE_COUNT + 32'd1;
            if (STALL) STALL_COUNT <= STALL_COUNT + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed table, hand sequences and random stimulus against a behavioural model
module tb_id_ex_stage;
    logic clk = 1'b0, rst = 1'b1, stall, flush, in_valid;
    logic [31:0] in_pc, in_rdata1, in_rdata2, in_imm, mem_result, wb_result;
    logic [4:0] in_aluop, in_rs1, in_rs2, in_rd, mem_rd, wb_rd;
    logic in_src1_pc, in_src2_imm, in_rw, in_mr, in_mw, mem_rw, wb_rw;
    logic [31:0] data1, data2, store_data;
    logic [4:0] sel, rd;
    logic reg_write, mem_read, mem_write, valid, hazard;
`ifdef ID_EX_PERF_COUNT_EN
    logic [31:0] bubble_count, stall_count;
`endif
    int tests = 0, fails = 0;

    typedef struct packed {
        logic valid;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0] op, rs1, rs2, rd;
        logic rw, mr, mw;
    } instr_t;
    instr_t cur;
    int unsigned m_bubbles, m_stalls;

    typedef struct {
        logic mrw;
        logic [4:0] mrd;
        logic wrw;
        logic [4:0] wrd;
        logic [31:0] exp;
    } fwd_vec_t;
    fwd_vec_t fvec [6];

    id_ex_stage dut (
        .CLK(clk), .RESET(rst), .STALL(stall), .FLUSH(flush), .IN_VALID(in_valid),
        .IN_PC(in_pc), .IN_RDATA1(in_rdata1), .IN_RDATA2(in_rdata2), .IN_IMM(in_imm),
        .IN_ALUOP(in_aluop), .IN_RS1(in_rs1), .IN_RS2(in_rs2), .IN_RD(in_rd),
        .IN_SRC1_PC(in_src1_pc), .IN_SRC2_IMM(in_src2_imm), .IN_REG_WRITE(in_rw),
        .IN_MEM_READ(in_mr), .IN_MEM_WRITE(in_mw), .MEM_RD(mem_rd), .MEM_REG_WRITE(mem_rw),
        .MEM_RESULT(mem_result), .WB_RD(wb_rd), .WB_REG_WRITE(wb_rw), .WB_RESULT(wb_result),
        .DATA1(data1), .DATA2(data2), .SELECT(sel), .STORE_DATA(store_data), .RD(rd),
        .REG_WRITE(reg_write), .MEM_READ(mem_read), .MEM_WRITE(mem_write), .VALID(valid),
        .HAZARD_STALL(hazard)
`ifdef ID_EX_PERF_COUNT_EN
        , .BUBBLE_COUNT(bubble_count), .STALL_COUNT(stall_count)
`endif
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        {stall, flush, in_valid, in_src1_pc, in_src2_imm, in_rw, in_mr, in_mw, mem_rw, wb_rw} = '0;
        {in_pc, in_rdata1, in_rdata2, in_imm, mem_result, wb_result} = '0;
        {in_aluop, in_rs1, in_rs2, in_rd, mem_rd, wb_rd} = '0;
    endtask

    function automatic logic [31:0] mfwd(input logic [4:0] rs, input logic [31:0] v);
        if (rs == 0) return v;
        if (mem_rw && mem_rd == rs) return mem_result;
        if (wb_rw && wb_rd == rs) return wb_result;
        return v;
    endfunction

    function automatic logic m_hazard();
        return cur.valid && cur.mr && cur.rd != 0 && in_valid &&
               (in_rs1 == cur.rd || in_rs2 == cur.rd) && !stall && !flush;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, " VALID"}, 32'(valid), 32'(cur.valid));
        chk({tag, " REG_WRITE"}, 32'(reg_write), 32'(cur.valid & cur.rw));
        chk({tag, " MEM_READ"}, 32'(mem_read), 32'(cur.valid & cur.mr));
        chk({tag, " MEM_WRITE"}, 32'(mem_write), 32'(cur.valid & cur.mw));
        chk({tag, " HAZARD_STALL"}, 32'(hazard), 32'(m_hazard()));
        if (cur.valid) begin
            chk({tag, " DATA1"}, data1, in_src1_pc ? cur.pc : mfwd(cur.rs1, cur.r1));
            chk({tag, " DATA2"}, data2, in_src2_imm ? cur.imm : mfwd(cur.rs2, cur.r2));
            chk({tag, " STORE_DATA"}, store_data, mfwd(cur.rs2, cur.r2));
            chk({tag, " SELECT"}, 32'(sel), 32'(cur.op));
            chk({tag, " RD"}, 32'(rd), 32'(cur.rd));
        end
`ifdef ID_EX_PERF_COUNT_EN
        chk({tag, " BUBBLE_COUNT"}, bubble_count, m_bubbles);
        chk({tag, " STALL_COUNT"}, stall_count, m_stalls);
`endif
    endtask

    task automatic model_next();
        instr_t nxt;
        logic hz;
        hz = m_hazard();
        nxt = cur;
        if (stall) m_stalls++;
        if (flush || (!stall && hz)) begin
            nxt.valid = 0; nxt.rw = 0; nxt.mr = 0; nxt.mw = 0;
            if (hz) m_bubbles++;
        end else if (stall) begin
            nxt.r1 = mfwd(cur.rs1, cur.r1);
            nxt.r2 = mfwd(cur.rs2, cur.r2);
        end else begin
            nxt = '{in_valid, in_pc, in_rdata1, in_rdata2, in_imm, in_aluop,
                    in_rs1, in_rs2, in_rd, in_rw, in_mr, in_mw};
        end
        cur = nxt;
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input string tag);
        #1;
        check_all(tag);
        tick();
    endtask

    task automatic model_reset();
        cur = '0;
        m_bubbles = 0;
        m_stalls = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " DATA1"}, data1, 0);
        chk({tag, " DATA2"}, data2, 0);
        chk({tag, " STORE_DATA"}, store_data, 0);
        chk({tag, " SELECT"}, 32'(sel), 0);
        chk({tag, " RD"}, 32'(rd), 0);
        chk({tag, " CTRL"}, {29'd0, reg_write, mem_read, mem_write}, 0);
        chk({tag, " VALID"}, 32'(valid), 0);
        chk({tag, " HAZARD_STALL"}, 32'(hazard), 0);
`ifdef ID_EX_PERF_COUNT_EN
        chk({tag, " COUNTERS"}, bubble_count | stall_count, 0);
`endif
    endtask

    initial begin
        fvec[0] = '{1, 3, 1, 3, 32'hAA};
        fvec[1] = '{0, 3, 1, 3, 32'hBB};
        fvec[2] = '{1, 5, 1, 3, 32'hBB};
        fvec[3] = '{0, 3, 0, 3, 32'h11};
        fvec[4] = '{1, 3, 0, 7, 32'hAA};
        fvec[5] = '{1, 0, 1, 0, 32'h11};
        clear_inputs();
        model_reset();
        #3;
        check_zero("reset");
        @(negedge clk);
        rst = 0;
        step("post-reset");

        in_valid = 1; in_rdata1 = 5; in_rdata2 = 7; in_rs1 = 1; in_rs2 = 2; in_rd = 3; in_rw = 1;
        step("add load");
        clear_inputs();
        #1;
        chk("add DATA1", data1, 5);
        chk("add DATA2", data2, 7);
        chk("add SELECT", 32'(sel), 0);
        chk("add VALID", 32'(valid), 1);
        tick();

        in_valid = 1; in_rs1 = 3; in_rdata1 = 32'h11; in_rd = 8; in_rw = 1;
        step("fwd load");
        clear_inputs();
        mem_result = 32'hAA; wb_result = 32'hBB;
        for (int i = 0; i < 6; i++) begin
            mem_rw = fvec[i].mrw; mem_rd = fvec[i].mrd; wb_rw = fvec[i].wrw; wb_rd = fvec[i].wrd;
            #1;
            chk($sformatf("fwd vec%0d DATA1", i), data1, fvec[i].exp);
        end
        tick();

        clear_inputs();
        in_valid = 1; in_rs1 = 0; in_rdata1 = 32'h22;
        step("x0 load");
        clear_inputs();
        mem_rw = 1; mem_rd = 0; mem_result = 32'hAA; wb_rw = 1; wb_rd = 0; wb_result = 32'hBB;
        #1;
        chk("x0 DATA1", data1, 32'h22);
        tick();

        clear_inputs();
        in_valid = 1; in_rd = 4; in_mr = 1; in_rw = 1; in_rs1 = 1;
        step("lw load");
        clear_inputs();
        in_valid = 1; in_rs1 = 9; in_rs2 = 4;
        #1;
        chk("load-use HAZARD_STALL", 32'(hazard), 1);
        step("load-use");
        #1;
        chk("bubble VALID", 32'(valid), 0);
        chk("bubble REG_WRITE", 32'(reg_write), 0);
        chk("bubble HAZARD_STALL", 32'(hazard), 0);
        tick();

        clear_inputs();
        in_valid = 1; in_rs2 = 6; in_rdata2 = 32'h55; in_rd = 7; in_rw = 1;
        step("refresh load");
        clear_inputs();
        stall = 1; wb_rw = 1; wb_rd = 6; wb_result = 32'h1234;
        #1;
        chk("refresh c0 DATA2", data2, 32'h1234);
        tick();
        wb_rw = 0; wb_result = 0;
        for (int i = 1; i < 3; i++) begin
            #1;
            chk($sformatf("refresh c%0d DATA2", i), data2, 32'h1234);
            check_all("refresh");
            tick();
        end

        clear_inputs();
        in_valid = 1; in_rd = 5; in_rw = 1; in_mw = 1;
        step("sf load");
        clear_inputs();
        stall = 1; flush = 1;
        step("stall+flush");
        #1;
        chk("stall+flush VALID", 32'(valid), 0);
`ifdef ID_EX_PERF_COUNT_EN
        chk("stall+flush STALL_COUNT", stall_count, m_stalls);
        chk("stall+flush BUBBLE_COUNT", bubble_count, m_bubbles);
`endif
        tick();

        clear_inputs();
        in_valid = 1; in_rs1 = 3; in_rdata1 = 32'h99; in_aluop = 5'd7; in_rd = 2; in_rw = 1;
        step("midreset load");
        clear_inputs();
        mem_rw = 1; mem_rd = 3; mem_result = 32'hAA; stall = 1;
        #3;
        rst = 1;
        #1;
        check_zero("mid-reset");
        model_reset();
        @(negedge clk);
        rst = 0;
        clear_inputs();
        step("after reset");
        #1;
        chk("after reset VALID", 32'(valid), 0);
        tick();

        for (int n = 0; n < 500; n++) begin
            in_valid = ($urandom % 4) != 0;
            in_pc = $urandom; in_rdata1 = $urandom; in_rdata2 = $urandom; in_imm = $urandom;
            in_aluop = 5'($urandom);
            in_rs1 = 5'($urandom % 8); in_rs2 = 5'($urandom % 8); in_rd = 5'($urandom % 8);
            in_src1_pc = 1'($urandom); in_src2_imm = 1'($urandom);
            in_rw = 1'($urandom); in_mr = 1'($urandom); in_mw = 1'($urandom);
            mem_rw = 1'($urandom); mem_rd = 5'($urandom % 8); mem_result = $urandom;
            wb_rw = 1'($urandom); wb_rd = 5'($urandom % 8); wb_result = $urandom;
            stall = ($urandom % 5) == 0;
            flush = ($urandom % 8) == 0;
            step("rand");
        end
        #1;
        check_all("final");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU in the RISC-V pipeline.
- Latches decoded operands, immediate, ALU opcode and control bits from decode.
- Resolves EX/MEM and MEM/WB forwarding and picks the ALU operand sources.
- Detects load-use hazards and drives DATA1/DATA2/SELECT into the ALU.

Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register-address width
- OP_W, 5, ALU opcode width (matches ALU SELECT)

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- STALL  in  1  downstream hold request; register keeps its content
- FLUSH  in  1  squash: next state is a bubble
- IN_VALID  in  1  decode slot holds a real instruction
- IN_PC  in  XLEN  instruction PC
- IN_RDATA1, IN_RDATA2  in  XLEN  register-file read data
- IN_IMM  in  XLEN  sign-extended immediate
- IN_ALUOP  in  OP_W  ALU opcode
- IN_RS1, IN_RS2, IN_RD  in  RA_W  source and destination register indices
- IN_SRC1_PC  in  1  operand 1 = PC instead of rs1
- IN_SRC2_IMM  in  1  operand 2 = IMM instead of rs2
- IN_REG_WRITE, IN_MEM_READ, IN_MEM_WRITE  in  1  control bits
- MEM_RD  in  RA_W  destination of the instruction in EX/MEM
- MEM_REG_WRITE  in  1  write enable of the instruction in EX/MEM
- MEM_RESULT  in  XLEN  result of the instruction in EX/MEM
- WB_RD  in  RA_W  destination of the instruction in MEM/WB
- WB_REG_WRITE  in  1  write enable of the instruction in MEM/WB
- WB_RESULT  in  XLEN  result of the instruction in MEM/WB
- DATA1, DATA2  out  XLEN  ALU operands
- SELECT  out  OP_W  ALU opcode
- STORE_DATA  out  XLEN  forwarded rs2 value for stores
- RD  out  RA_W  destination register
- REG_WRITE, MEM_READ, MEM_WRITE  out  1  control bits, gated by VALID
- VALID  out  1  stage holds a real instruction
- HAZARD_STALL  out  1  load-use stall request to IF/ID

Behaviour:
- Reset (asynchronous): VALID=0, all stored fields=0.
  - Outputs during reset: DATA1=DATA2=STORE_DATA=0, SELECT=0 (ADD), RD=0, REG_WRITE=MEM_READ=MEM_WRITE=0, HAZARD_STALL=0.
- Registered fields update #1 after the CLK rising edge.
- Next-state priority, per rising edge:
  - FLUSH: load a bubble (VALID=0, controls=0).
  - else STALL: hold all fields, except the operand refresh below.
  - else HAZARD_STALL: load a bubble; IF/ID holds the decode instruction.
  - else: load the IN_* fields; VALID=IN_VALID.
- Bubbles: REG_WRITE, MEM_READ and MEM_WRITE are forced to 0 whenever VALID=0.
- Forwarding, combinational, applied to stored rs1val and rs2val:
  - If MEM_REG_WRITE && MEM_RD!=0 && MEM_RD==rs, use MEM_RESULT.
  - else if WB_REG_WRITE && WB_RD!=0 && WB_RD==rs, use WB_RESULT.
  - else use the stored value.
  - MEM beats WB when both match. x0 is never forwarded.
- Operand refresh: while STALL=1 and no FLUSH, each edge writes the forwarded rs1/rs2 values back into storage. A producer that retires during a stall is therefore not lost.
- Operand selection:
  - DATA1 = IN_SRC1_PC ? stored PC : fwd rs1.
  - DATA2 = IN_SRC2_IMM ? stored IMM : fwd rs2.
  - STORE_DATA = fwd rs2 always.
- Latency: one cycle from decode to ALU inputs.
- Load-use detection: HAZARD_STALL = VALID && MEM_READ && RD!=0 && IN_VALID && (IN_RS1==RD || IN_RS2==RD).
  - Combinational.
  - Forced to 0 while STALL or FLUSH is high, since those take priority.
- Simultaneous STALL and FLUSH: FLUSH wins.
- Reset mid-stall: everything clears immediately, with no wait for a clock edge.

Optional Feature:
- Macro: ID_EX_PERF_COUNT_EN.
- When defined, two extra outputs are present:
  - BUBBLE_COUNT [31:0]: increments on every edge that loads a hazard bubble.
  - STALL_COUNT [31:0]: increments on every edge with STALL=1.
- Both counters wrap at 2^32, clear on RESET, and FLUSH does not clear them.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset asserted mid-cycle -> all outputs 0 immediately; VALID=0 until the first load with IN_VALID=1.
- Load ADD: rdata1=5, rdata2=7, IN_ALUOP=0, SRC sels 0 -> next cycle DATA1=5, DATA2=7, SELECT=0, VALID=1.
- Forward priority: stored rs1=x3; MEM_RD=3 with MEM_RESULT=0xAA and WB_RD=3 with WB_RESULT=0xBB, both write-enabled -> DATA1=0xAA. Drop MEM_REG_WRITE -> DATA1=0xBB. Set rs1=x0 -> DATA1=stored value.
- Load-use: stage holds LW rd=x4 (MEM_READ=1); IN_RS2=4, IN_VALID=1 -> HAZARD_STALL=1; next edge VALID=0, REG_WRITE=0; HAZARD_STALL then drops.
- Stall refresh: STALL=1 for 3 cycles with WB_RD=rs2, WB_RESULT=0x1234 for the first cycle only -> DATA2 stays 0x1234 through the remaining stall cycles.
- STALL=1 and FLUSH=1 together -> bubble loaded (VALID=0). With ID_EX_PERF_COUNT_EN defined: STALL_COUNT +1, BUBBLE_COUNT unchanged.
